// File: rtl/mod_cu.sv
// Control unit for the repeated-subtraction modulo datapath: sequences mod_dp
// enables from ltb, counts subtractions as the quotient and rejects bad divisors.
module mod_cu #(
  parameter logic [31:0] MAX_ITER = 32'h8000_0000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] b,
  input  logic        ltb,
  output logic        we,
  output logic        selA,
  output logic        saveSub,
  output logic        saveResult,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] quotient
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    UPDATE,
    STORE,
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [1:0]  err_code;
  logic [1:0]  nxt_code;

  always_comb begin
    nxt      = state;
    nxt_code = err_code;
    case (state)
      IDLE: begin
        if (start) begin
          if (b == '0) begin
            nxt      = ERR;
            nxt_code = 2'b01;
          end else if (b[31]) begin
            nxt      = ERR;
            nxt_code = 2'b10;
          end else begin
            nxt      = LOAD;
          end
        end
      end
      LOAD:   nxt = CHECK;
      CHECK: begin
        if (ltb) begin
          nxt = STORE;
        end else if (quotient == MAX_ITER) begin
          nxt      = ERR;
          nxt_code = 2'b11;
        end else begin
          nxt = UPDATE;
        end
      end
      UPDATE: nxt = CHECK;
      STORE:  nxt = DONE;
      DONE:   nxt = IDLE;
      ERR:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each one equals a pure
  // decode of the current state without a combinational path to the ports.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      err_code   <= 2'b00;
      we         <= 1'b0;
      selA       <= 1'b0;
      saveSub    <= 1'b0;
      saveResult <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 2'b00;
      quotient   <= '0;
    end else begin
      state      <= nxt;
      err_code   <= nxt_code;
      we         <= (nxt == LOAD) || (nxt == UPDATE);
      selA       <= (nxt == LOAD);
      saveSub    <= (nxt == CHECK);
      saveResult <= (nxt == STORE);
      busy       <= (nxt != IDLE);
      done       <= (nxt == DONE) || (nxt == ERR);
      err        <= (nxt == ERR) ? nxt_code : 2'b00;
      if (nxt == LOAD) begin
        quotient <= '0;
      end else if (nxt == UPDATE) begin
        quotient <= quotient + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mod_cu.sv
// Self-checking bench for mod_cu: two instances (default and MAX_ITER=4) drive a
// behavioural mod_dp model; results are compared against plain integer division.
module tb_mod_cu;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;

  logic [1:0]  ltb_v, we_v, selA_v, sub_v, sr_v, busy_v, done_v;
  logic [1:0]  err_v [2];
  logic [31:0] q_v [2];

  logic [31:0] temp [2];
  logic [31:0] subr [2];
  logic [31:0] res  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  mod_cu u0 (
    .CLK(CLK), .reset(reset), .start(start), .b(b), .ltb(ltb_v[0]),
    .we(we_v[0]), .selA(selA_v[0]), .saveSub(sub_v[0]), .saveResult(sr_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .quotient(q_v[0])
  );

  mod_cu #(.MAX_ITER(32'd4)) u1 (
    .CLK(CLK), .reset(reset), .start(start), .b(b), .ltb(ltb_v[1]),
    .we(we_v[1]), .selA(selA_v[1]), .saveSub(sub_v[1]), .saveResult(sr_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .quotient(q_v[1])
  );

  // Behavioural mod_dp: temp/subReg/result registers and the ltb flag.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        temp[i] <= '0;
        subr[i] <= '0;
        res[i]  <= '0;
      end else begin
        if (we_v[i])   temp[i] <= selA_v[i] ? a : subr[i];
        if (sub_v[i])  subr[i] <= temp[i] - b;
        if (sr_v[i])   res[i]  <= temp[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) ltb_v[i] = ($signed(temp[i]) < $signed(b));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic op(input string tag, input logic [31:0] aa, input logic [31:0] bb, input bit poke);
    logic [31:0] mx, qq;
    logic [1:0]  e_err [2];
    logic [31:0] e_q [2], e_r [2];
    int          e_n [2], e_we [2], e_ss [2], e_sr [2], e_sel [2];
    int          c_we [2], c_ss [2], c_sr [2], c_sel [2];
    bit          got [2];
    for (int i = 0; i < 2; i++) begin
      mx = (i == 1) ? 32'd4 : 32'h8000_0000;
      e_q[i] = q_v[i];
      e_r[i] = res[i];
      c_we[i] = 0; c_ss[i] = 0; c_sr[i] = 0; c_sel[i] = 0; got[i] = 0;
      if (bb == 0 || bb[31]) begin
        e_err[i] = (bb == 0) ? 2'b01 : 2'b10;
        e_n[i] = 1; e_we[i] = 0; e_ss[i] = 0; e_sr[i] = 0; e_sel[i] = 0;
      end else if ($signed(aa) < 0) begin
        e_err[i] = 2'b00; e_q[i] = 0; e_r[i] = aa;
        e_n[i] = 4; e_we[i] = 1; e_ss[i] = 1; e_sr[i] = 1; e_sel[i] = 1;
      end else begin
        qq = aa / bb;
        if (qq > mx) begin
          e_err[i] = 2'b11; e_q[i] = mx;
          e_n[i] = 2 * int'(mx) + 3;
          e_we[i] = int'(mx) + 1; e_ss[i] = int'(mx) + 1; e_sr[i] = 0; e_sel[i] = 1;
        end else begin
          e_err[i] = 2'b00; e_q[i] = qq; e_r[i] = aa % bb;
          e_n[i] = 2 * int'(qq) + 4;
          e_we[i] = int'(qq) + 1; e_ss[i] = int'(qq) + 1; e_sr[i] = 1; e_sel[i] = 1;
        end
      end
    end
    a = aa;
    b = bb;
    start = 1'b1;
    for (int n = 1; n <= 800 && !(got[0] && got[1]); n++) begin
      @(posedge CLK); #1;
      if (n == 1) start = 1'b0;
      if (poke && n == 2) start = 1'b1;
      if (poke && n == 3) start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (!got[i]) begin
          c_we[i]  += int'(we_v[i]);
          c_ss[i]  += int'(sub_v[i]);
          c_sr[i]  += int'(sr_v[i]);
          c_sel[i] += int'(selA_v[i]);
          if (done_v[i]) begin
            got[i] = 1;
            check($sformatf("%s u%0d latency", tag, i), n, e_n[i]);
            check($sformatf("%s u%0d err", tag, i), err_v[i], e_err[i]);
            check($sformatf("%s u%0d busy", tag, i), busy_v[i], 1);
            check($sformatf("%s u%0d result", tag, i), res[i], e_r[i]);
            check($sformatf("%s u%0d enables", tag, i),
                  {c_we[i][7:0], c_ss[i][7:0], c_sr[i][7:0], c_sel[i][7:0]},
                  {e_we[i][7:0], e_ss[i][7:0], e_sr[i][7:0], e_sel[i][7:0]});
            if (e_err[i] != 2'b01 && e_err[i] != 2'b10)
              check($sformatf("%s u%0d quotient", tag, i), q_v[i], e_q[i]);
          end
        end
      end
    end
    for (int i = 0; i < 2; i++)
      if (!got[i]) check($sformatf("%s u%0d done timeout", tag, i), 0, 1);
    @(posedge CLK); #1;
    check({tag, " post done/busy/err"}, {done_v, busy_v, err_v[0], err_v[1]}, '0);
  endtask

  initial begin
    logic [1:0]  dn;
    logic [31:0] ra, rb;
    int          f;
    bit          fin, seen;
    int          kind;

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
    check("reset ctrl", {busy_v, done_v, we_v, selA_v, sub_v, sr_v}, '0);
    check("reset err", {err_v[0], err_v[1]}, '0);
    check("reset quotient u0", q_v[0], 0);
    check("reset quotient u1", q_v[1], 0);

    op("basic", 32'd17, 32'd5, 1'b0);
    op("a<b", 32'd3, 32'd5, 1'b0);
    op("exact", 32'd20, 32'd5, 1'b0);
    op("bzero", 32'd42, 32'd0, 1'b0);
    op("bneg", 32'd42, 32'hFFFF_FFFB, 1'b0);
    op("timeout", 32'd100, 32'd1, 1'b0);
    op("nega", -32'sd7, 32'd3, 1'b0);

    // Reset while the first UPDATE is active.
    a = 32'd17; b = 32'd5; start = 1'b1; seen = 0;
    for (int n = 1; n <= 30 && !seen; n++) begin
      @(posedge CLK); #1;
      start = 1'b0;
      if (we_v[0] && !selA_v[0]) seen = 1;
    end
    check("midreset reach update", seen, 1);
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0;
    check("midreset busy/done", {busy_v, done_v}, '0);
    check("midreset quotient u0", q_v[0], 0);
    check("midreset quotient u1", q_v[1], 0);
    dn = '0;
    repeat (15) begin
      @(posedge CLK); #1;
      dn |= done_v;
    end
    check("midreset no done", dn, '0);

    op("busy start", 32'd17, 32'd5, 1'b1);

    // Start held high across two operations.
    a = 32'd17; b = 32'd5; start = 1'b1; f = 0; fin = 0;
    for (int n = 1; n <= 80 && !fin; n++) begin
      @(posedge CLK); #1;
      if (f != 0 && n == f + 2) start = 1'b0;
      if (done_v[0]) begin
        check("b2b u1 done", done_v[1], 1);
        if (f == 0) begin
          f = n;
          check("b2b first latency", n, 2 * (17 / 5) + 4);
          check("b2b q1 u0", q_v[0], 17 / 5);
          check("b2b q1 u1", q_v[1], 17 / 5);
          a = 32'd9; b = 32'd4;
        end else begin
          fin = 1;
          check("b2b gap", n - f, 2 * (9 / 4) + 5);
          check("b2b q2 u0", q_v[0], 9 / 4);
          check("b2b q2 u1", q_v[1], 9 / 4);
          check("b2b result", res[0], 9 % 4);
        end
      end
    end
    if (!fin) check("b2b done timeout", 0, 1);
    start = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    for (int k = 0; k < 12; k++) begin
      kind = $urandom_range(0, 9);
      ra = $urandom_range(0, 300);
      rb = $urandom_range(1, 25);
      if (kind == 0) rb = '0;
      else if (kind == 1) rb = -$urandom_range(1, 100);
      else if (kind == 2) ra = -$urandom_range(1, 1000);
      op($sformatf("rand%0d", k), ra, rb, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
